// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared Tomasulo definitions used by the reservation stations and the common
// data bus (CDB) arbiter: requester count and indices, the reserved
// "no producer" tag, CDB payload field widths and a small helper.
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

    // Number of functional units competing for the CDB.
    localparam int CDB_NUM_REQ   = 4;

    // Requester indices on the arbiter's request vector.
    localparam int REQ_ADD_RS    = 0;
    localparam int REQ_MULDIV_RS = 1;
    localparam int REQ_LSU       = 2;
    localparam int REQ_LOGIC_RS  = 3;

    // CDB payload field widths.
    localparam int CDB_TAG_W     = 5;
    localparam int CDB_VAL_W     = 32;
    localparam int CDB_FLAGS_W   = 4;
    localparam int CDB_CNT_W     = 16;

    // Tag value that names no producer; a result carrying it is never broadcast.
    localparam logic [CDB_TAG_W-1:0] CDB_INVALID_TAG = 5'b11111;

    // One CDB transfer as registered by the arbiter.
    typedef struct packed {
        logic [CDB_TAG_W-1:0]   tag;
        logic [CDB_VAL_W-1:0]   val;
        logic [CDB_FLAGS_W-1:0] flags;
        logic                   icc_write;
    } cdb_payload_t;

    // True when two or more bits of the vector are set.
    function automatic logic multi_hot(input logic [31:0] vec);
        return ((vec & (vec - 32'd1)) != 32'd0);
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin picker. Searches the eligible vector starting at
// index ptr, ascending and wrapping, and returns the first hit one-hot.
// Ports:
//   eligible [NUM_REQ]  candidates for this cycle
//   ptr      [PTR_W]    first index to examine (must be < NUM_REQ)
//   winner   [NUM_REQ]  one-hot winner, all zero when nothing is eligible
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner
);

    logic [PTR_W-1:0] idx_s;
    logic             found_s;
    logic             hit_s;

    // Walk the ring once from ptr; each slot is visited exactly once, so the
    // first eligible slot is the only one that can raise its winner bit.
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx_s         = PTR_W'((int'(ptr) + off) % NUM_REQ);
            hit_s         = eligible[idx_s] & ~found_s;
            winner[idx_s] = hit_s;
            found_s       = found_s | hit_s;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter for the Tomasulo common data bus. Each cycle at most one
// requesting functional unit is granted; its result is registered onto the CDB
// one cycle after the request is sampled. A unit granted on one edge is masked
// on the next edge so its own still-high request is not served twice.
// Ports:
//   clk, in_reset          clock, synchronous active-high reset
//   in_req[NUM_REQ]        level requests, held until granted
//   in_tag/in_val/in_ICC_flags/in_ICC_write   per-unit result payload
//   in_CDB_hold            downstream stall, blocks new grants
//   out_grant              one-hot grant pulse to the winner
//   out_CDB_broadcast      CDB valid pulse
//   out_CDB_tag/out_CDB_val/out_ICC_flags/out_ICC_write   CDB payload
//   out_bad_tag            winner carried INVALID_TAG (grant without broadcast)
//   out_conflict_cnt       saturating count of contended arbitration cycles
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int                   NUM_REQ     = CDB_NUM_REQ,
    parameter logic [CDB_TAG_W-1:0] INVALID_TAG = CDB_INVALID_TAG
) (
    input  logic                                   clk,
    input  logic                                   in_reset,
    input  logic [NUM_REQ-1:0]                     in_req,
    input  logic [NUM_REQ-1:0][CDB_TAG_W-1:0]      in_tag,
    input  logic [NUM_REQ-1:0][CDB_VAL_W-1:0]      in_val,
    input  logic [NUM_REQ-1:0][CDB_FLAGS_W-1:0]    in_ICC_flags,
    input  logic [NUM_REQ-1:0]                     in_ICC_write,
    input  logic                                   in_CDB_hold,
    output logic [NUM_REQ-1:0]                     out_grant,
    output logic                                   out_CDB_broadcast,
    output logic [CDB_TAG_W-1:0]                   out_CDB_tag,
    output logic [CDB_VAL_W-1:0]                   out_CDB_val,
    output logic [CDB_FLAGS_W-1:0]                 out_ICC_flags,
    output logic                                   out_ICC_write,
    output logic                                   out_bad_tag,
    output logic [CDB_CNT_W-1:0]                   out_conflict_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]     grant_r;
    logic                   bcast_r;
    logic                   bad_tag_r;
    cdb_payload_t           payload_r;
    logic [PTR_W-1:0]       ptr_r;
    logic [CDB_CNT_W-1:0]   cnt_r;

    logic [NUM_REQ-1:0]     eligible_s;
    logic [NUM_REQ-1:0]     winner_s;
    logic [PTR_W-1:0]       winner_idx_s;
    logic [PTR_W-1:0]       next_ptr_s;
    logic [CDB_TAG_W-1:0]   win_tag_s;
    logic [CDB_VAL_W-1:0]   win_val_s;
    logic [CDB_FLAGS_W-1:0] win_flags_s;
    logic                   win_wr_s;
    logic                   grant_now_s;
    logic                   conflict_s;
    logic                   win_bad_s;

    // The unit granted last cycle still holds its request this cycle.
    assign eligible_s = in_req & ~grant_r;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .eligible (eligible_s),
        .ptr      (ptr_r),
        .winner   (winner_s)
    );

    // One-hot winner to index and payload mux (AND-OR over a one-hot select).
    always_comb begin
        winner_idx_s = '0;
        win_tag_s    = '0;
        win_val_s    = '0;
        win_flags_s  = '0;
        win_wr_s     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            winner_idx_s = winner_idx_s | (winner_s[i] ? PTR_W'(i) : PTR_W'(0));
            win_tag_s    = win_tag_s    | ({CDB_TAG_W{winner_s[i]}}   & in_tag[i]);
            win_val_s    = win_val_s    | ({CDB_VAL_W{winner_s[i]}}   & in_val[i]);
            win_flags_s  = win_flags_s  | ({CDB_FLAGS_W{winner_s[i]}} & in_ICC_flags[i]);
            win_wr_s     = win_wr_s     | (winner_s[i] & in_ICC_write[i]);
        end
    end

    // Grant decision, contention detect and pointer advance past the winner.
    always_comb begin
        grant_now_s = (in_CDB_hold == 1'b0) && (eligible_s != '0);
        conflict_s  = grant_now_s && multi_hot(32'(eligible_s));
        win_bad_s   = (win_tag_s == INVALID_TAG);
        if (winner_idx_s == PTR_W'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = winner_idx_s + PTR_W'(1);
        end
    end

    // Grant, broadcast and payload registers; payload holds when nothing is sent.
    always_ff @(posedge clk) begin
        if (in_reset) begin
            grant_r             <= '0;
            bcast_r             <= 1'b0;
            bad_tag_r           <= 1'b0;
            ptr_r               <= '0;
            payload_r.tag       <= INVALID_TAG;
            payload_r.val       <= '0;
            payload_r.flags     <= '0;
            payload_r.icc_write <= 1'b0;
        end else if (grant_now_s) begin
            grant_r <= winner_s;
            ptr_r   <= next_ptr_s;
            if (win_bad_s) begin
                // Unit frees its entry, but the tag must not reach consumers.
                bcast_r   <= 1'b0;
                bad_tag_r <= 1'b1;
            end else begin
                bcast_r             <= 1'b1;
                bad_tag_r           <= 1'b0;
                payload_r.tag       <= win_tag_s;
                payload_r.val       <= win_val_s;
                payload_r.flags     <= win_flags_s;
                payload_r.icc_write <= win_wr_s;
            end
        end else begin
            grant_r   <= '0;
            bcast_r   <= 1'b0;
            bad_tag_r <= 1'b0;
        end
    end

    // Saturating count of arbitration cycles with competing eligible units.
    always_ff @(posedge clk) begin
        if (in_reset) begin
            cnt_r <= '0;
        end else if (conflict_s && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign out_grant         = grant_r;
    assign out_CDB_broadcast = bcast_r;
    assign out_bad_tag       = bad_tag_r;
    assign out_CDB_tag       = payload_r.tag;
    assign out_CDB_val       = payload_r.val;
    assign out_ICC_flags     = payload_r.flags;
    assign out_ICC_write     = payload_r.icc_write;
    assign out_conflict_cnt  = cnt_r;

endmodule
